// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and small helpers for bus masters on the SoC fabric.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Command size 3 has no meaning on this fabric; it is promoted to a word.
  function automatic hsize_e norm_size(input logic [1:0] size);
    case (size)
      2'd0:    return HSIZE_BYTE;
      2'd1:    return HSIZE_HALF;
      default: return HSIZE_WORD;
    endcase
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input hsize_e size);
    case (size)
      HSIZE_HALF: return {addr[31:1], 1'b0};
      HSIZE_WORD: return {addr[31:2], 2'b00};
      default:    return addr;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// Byte-lane steering: replicate write data onto all active lanes and extract
// right-aligned, zero-extended read data for byte/halfword/word accesses.
import ahb_pkg::*;

module ahb_lane_steer (
  input  hsize_e      i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_hwdata,
  output logic [31:0] o_rdata
);

  always_comb begin
    o_hwdata = i_wdata;
    o_rdata  = i_rdata;
    case (i_size)
      HSIZE_BYTE: begin
        o_hwdata = {4{i_wdata[7:0]}};
        case (i_addr_lo)
          2'd0:    o_rdata = {24'h0, i_rdata[7:0]};
          2'd1:    o_rdata = {24'h0, i_rdata[15:8]};
          2'd2:    o_rdata = {24'h0, i_rdata[23:16]};
          default: o_rdata = {24'h0, i_rdata[31:24]};
        endcase
      end
      HSIZE_HALF: begin
        o_hwdata = {2{i_wdata[15:0]}};
        o_rdata  = i_addr_lo[1] ? {16'h0, i_rdata[31:16]} : {16'h0, i_rdata[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_cmd_master.sv
// Single-master AHB-Lite initiator: valid/ready commands become pipelined
// single-beat transfers, with wait-state, two-cycle ERROR and cancel handling.
import ahb_pkg::*;

module ahb_cmd_master #(
  parameter logic [3:0] HPROT_VAL  = 4'b0011,
  parameter bit         ERR_CANCEL = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  logic        r_ap_valid, r_ap_write;
  logic [31:0] r_ap_addr, r_ap_wdata;
  hsize_e      r_ap_size;

  logic        r_dp_valid, r_dp_write;
  logic [1:0]  r_dp_lo;
  logic [31:0] r_dp_wdata;
  hsize_e      r_dp_size;

  logic        r_cancel_pend;
  logic        r_rsp_valid, r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_err_first, w_accept, w_cancel, w_dp_done;
  logic [31:0] w_hwdata, w_rd_lane;
  hsize_e      w_cmd_size;

  // First ERROR cycle: the slave is still stalling but has already flagged the fault.
  assign w_err_first = r_dp_valid && (HRESP == HRESP_ERROR) && !HREADY;
  assign cmd_ready   = (!r_ap_valid || HREADY) && !w_err_first;
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_cancel    = ERR_CANCEL && w_err_first && r_ap_valid;
  assign w_dp_done   = r_dp_valid && HREADY;
  assign w_cmd_size  = norm_size(cmd_size);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ap_valid <= 1'b0;
      r_ap_write <= 1'b0;
      r_ap_addr  <= '0;
      r_ap_wdata <= '0;
      r_ap_size  <= HSIZE_BYTE;
    end else if (w_cancel) begin
      r_ap_valid <= 1'b0;
    end else if (w_accept) begin
      r_ap_valid <= 1'b1;
      r_ap_write <= cmd_write;
      r_ap_addr  <= align_addr(cmd_addr, w_cmd_size);
      r_ap_wdata <= cmd_wdata;
      r_ap_size  <= w_cmd_size;
    end else if (HREADY) begin
      r_ap_valid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_lo    <= 2'b00;
      r_dp_wdata <= '0;
      r_dp_size  <= HSIZE_BYTE;
    end else if (HREADY) begin
      r_dp_valid <= r_ap_valid;
      if (r_ap_valid) begin
        r_dp_write <= r_ap_write;
        r_dp_lo    <= r_ap_addr[1:0];
        r_dp_wdata <= r_ap_wdata;
        r_dp_size  <= r_ap_size;
      end
    end
  end

  // A cancelled command reports only once the erroring transfer has drained,
  // which keeps responses in command order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cancel_pend <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      if (w_dp_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= HRESP;
        r_rsp_rdata <= r_dp_write ? 32'h0 : w_rd_lane;
      end else if (r_cancel_pend && !r_dp_valid) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_err     <= 1'b1;
        r_cancel_pend <= 1'b0;
      end
      if (w_cancel) r_cancel_pend <= 1'b1;
    end
  end

  ahb_lane_steer u_steer (
    .i_size    (r_dp_size),
    .i_addr_lo (r_dp_lo),
    .i_wdata   (r_dp_wdata),
    .i_rdata   (HRDATA),
    .o_hwdata  (w_hwdata),
    .o_rdata   (w_rd_lane)
  );

  assign HADDR     = r_ap_addr;
  assign HTRANS    = r_ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE    = r_ap_write;
  assign HSIZE     = r_ap_size;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = w_hwdata;

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = r_ap_valid || r_dp_valid || r_cancel_pend;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master with a small zero-wait SRAM slave model
// whose HREADY/HRESP are steered by the stimulus sequence.
module tb_ahb_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 HCLK = ~HCLK;

  ahb_cmd_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // SRAM slave model: 32 words, byte-lane writes in the data phase.
  logic [31:0] mem [0:31];
  logic        s_valid, s_write;
  logic [1:0]  s_size;
  logic [31:0] s_addr;
  int          s_b_seen;

  function automatic bit lane_en(input logic [1:0] sz, input logic [1:0] lo, input int b);
    if (sz == 2'd0) return (b == int'(lo));
    if (sz == 2'd1) return ((b / 2) == int'(lo[1]));
    return 1'b1;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_valid  <= 1'b0;
      s_write  <= 1'b0;
      s_size   <= 2'd0;
      s_addr   <= '0;
      s_b_seen <= 0;
      mem[8]   <= 32'h1234_5678;
    end else if (HREADY) begin
      if (s_valid && s_write)
        for (int b = 0; b < 4; b++)
          if (lane_en(s_size, s_addr[1:0], b)) mem[s_addr[6:2]][8*b +: 8] <= HWDATA[8*b +: 8];
      s_valid <= HTRANS[1];
      s_write <= HWRITE;
      s_size  <= HSIZE[1:0];
      s_addr  <= HADDR;
      if (HTRANS[1] && HADDR == 32'h30) s_b_seen <= s_b_seen + 1;
    end
  end

  assign HRDATA = mem[s_addr[6:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_size  = sz;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic idle_cmd;
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic e_err, input logic [31:0] e_data);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      tick;
      if (rsp_valid === 1'b1) got = 1'b1;
    end
    chk({tag, "_valid"}, {31'h0, got}, 32'h1);
    if (got) begin
      chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, e_err});
      chk({tag, "_rdata"}, rsp_rdata, e_data);
    end
  endtask

  initial begin
    HRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd0; cmd_addr = '0; cmd_wdata = '0;
    HREADY = 1'b1; HRESP = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_htrans", {30'h0, HTRANS}, 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("rst_hsize", {29'h0, HSIZE}, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("hprot", {28'h0, HPROT}, 32'h3);
    chk("hburst", {29'h0, HBURST}, 32'h0);
    chk("hmastlock", {31'h0, HMASTLOCK}, 32'h0);
    HRESETn = 1'b1;
    tick;

    // Word write then word read, back to back
    drive_cmd(1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF);
    #1 chk("wr_ready", {31'h0, cmd_ready}, 32'h1);
    tick;
    chk("wr_htrans", {30'h0, HTRANS}, 32'h2);
    chk("wr_haddr", HADDR, 32'h10);
    chk("wr_hwrite", {31'h0, HWRITE}, 32'h1);
    chk("wr_hsize", {29'h0, HSIZE}, 32'h2);
    chk("wr_busy", {31'h0, busy}, 32'h1);
    drive_cmd(1'b0, 2'd2, 32'h10, 32'h0);
    tick;
    chk("rd_htrans", {30'h0, HTRANS}, 32'h2);
    chk("rd_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
    idle_cmd;
    tick;
    chk("wr_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("after_rd_idle", {30'h0, HTRANS}, 32'h0);
    tick;
    chk("rd_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    tick;
    chk("rd_rsp_pulse", {31'h0, rsp_valid}, 32'h0);
    chk("rd_busy_clr", {31'h0, busy}, 32'h0);

    // Byte write and reads of the updated lane
    drive_cmd(1'b1, 2'd0, 32'h13, 32'h0000_00A5);
    tick;
    chk("bwr_haddr", HADDR, 32'h13);
    chk("bwr_hsize", {29'h0, HSIZE}, 32'h0);
    idle_cmd;
    tick;
    chk("bwr_hwdata", HWDATA, 32'hA5A5_A5A5);
    expect_rsp("bwr", 1'b0, 32'h0);
    drive_cmd(1'b0, 2'd2, 32'h10, 32'h0); tick; idle_cmd;
    expect_rsp("wrd_after_b", 1'b0, 32'hA5AD_BEEF);
    drive_cmd(1'b0, 2'd0, 32'h13, 32'h0); tick; idle_cmd;
    expect_rsp("brd_13", 1'b0, 32'h0000_00A5);
    drive_cmd(1'b0, 2'd0, 32'h12, 32'h0); tick; idle_cmd;
    expect_rsp("brd_12", 1'b0, 32'h0000_00AD);

    // Halfword accesses
    drive_cmd(1'b0, 2'd1, 32'h23, 32'h0);
    tick;
    chk("hrd_haddr", HADDR, 32'h22);
    chk("hrd_hsize", {29'h0, HSIZE}, 32'h1);
    idle_cmd;
    expect_rsp("hrd_23", 1'b0, 32'h0000_1234);
    drive_cmd(1'b1, 2'd1, 32'h26, 32'h0000_5A3C);
    tick;
    chk("hwr_haddr", HADDR, 32'h26);
    idle_cmd;
    tick;
    chk("hwr_hwdata", HWDATA, 32'h5A3C_5A3C);
    expect_rsp("hwr", 1'b0, 32'h0);
    drive_cmd(1'b0, 2'd1, 32'h26, 32'h0); tick; idle_cmd;
    expect_rsp("hrd_26", 1'b0, 32'h0000_5A3C);
    drive_cmd(1'b0, 2'd3, 32'h22, 32'h0);
    tick;
    chk("sz3_haddr", HADDR, 32'h20);
    chk("sz3_hsize", {29'h0, HSIZE}, 32'h2);
    idle_cmd;
    expect_rsp("sz3_rd", 1'b0, 32'h1234_5678);

    // Three wait states on read X while read Y waits in the address phase
    drive_cmd(1'b0, 2'd2, 32'h10, 32'hCAFE_F00D);
    tick;
    drive_cmd(1'b0, 2'd2, 32'h20, 32'h0);
    tick;
    idle_cmd;
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ws_haddr", HADDR, 32'h20);
      chk("ws_htrans", {30'h0, HTRANS}, 32'h2);
      chk("ws_ready", {31'h0, cmd_ready}, 32'h0);
      chk("ws_hwdata", HWDATA, 32'hCAFE_F00D);
      chk("ws_no_rsp", {31'h0, rsp_valid}, 32'h0);
      tick;
    end
    HREADY = 1'b1;
    #1 chk("ws_ready_back", {31'h0, cmd_ready}, 32'h1);
    tick;
    chk("ws_rspx_valid", {31'h0, rsp_valid}, 32'h1);
    chk("ws_rspx_rdata", rsp_rdata, 32'hA5AD_BEEF);
    tick;
    chk("ws_rspy_valid", {31'h0, rsp_valid}, 32'h1);
    chk("ws_rspy_rdata", rsp_rdata, 32'h1234_5678);
    tick;
    chk("ws_rsp_done", {31'h0, rsp_valid}, 32'h0);

    // Two-cycle ERROR on A with B in the address phase (cancelled)
    drive_cmd(1'b0, 2'd2, 32'h10, 32'h0);
    tick;
    drive_cmd(1'b1, 2'd2, 32'h30, 32'h1111_1111);
    tick;
    idle_cmd;
    HREADY = 1'b0;
    HRESP  = 1'b1;
    #1 chk("err1_ready", {31'h0, cmd_ready}, 32'h0);
    tick;
    HREADY = 1'b1;
    #1;
    chk("err2_idle", {30'h0, HTRANS}, 32'h0);
    chk("err2_no_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("err2_busy", {31'h0, busy}, 32'h1);
    chk("err2_ready", {31'h0, cmd_ready}, 32'h1);
    tick;
    HRESP = 1'b0;
    chk("errA_valid", {31'h0, rsp_valid}, 32'h1);
    chk("errA_err", {31'h0, rsp_err}, 32'h1);
    tick;
    chk("errB_valid", {31'h0, rsp_valid}, 32'h1);
    chk("errB_err", {31'h0, rsp_err}, 32'h1);
    chk("errB_rdata", rsp_rdata, 32'h0);
    tick;
    chk("err_done", {31'h0, rsp_valid}, 32'h0);
    chk("err_busy", {31'h0, busy}, 32'h0);
    chk("errB_not_on_bus", s_b_seen, 32'h0);

    // Eight back-to-back word writes
    for (int i = 0; i < 8; i++) begin
      drive_cmd(1'b1, 2'd2, 32'h40 + 32'(4 * i), 32'h100 + 32'(i));
      tick;
      chk("b2b_htrans", {30'h0, HTRANS}, 32'h2);
      chk("b2b_haddr", HADDR, 32'h40 + 32'(4 * i));
      chk("b2b_rsp", {31'h0, rsp_valid}, (i >= 2) ? 32'h1 : 32'h0);
    end
    idle_cmd;
    tick;
    chk("b2b_idle", {30'h0, HTRANS}, 32'h0);
    chk("b2b_rsp7", {31'h0, rsp_valid}, 32'h1);
    tick;
    chk("b2b_rsp8", {31'h0, rsp_valid}, 32'h1);
    tick;
    chk("b2b_rsp_end", {31'h0, rsp_valid}, 32'h0);
    drive_cmd(1'b0, 2'd2, 32'h5C, 32'h0); tick; idle_cmd;
    expect_rsp("b2b_readback", 1'b0, 32'h0000_0107);

    // Reset asserted mid-stream
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b1, 2'd2, 32'h60 + 32'(4 * i), 32'h200 + 32'(i));
      tick;
    end
    HRESETn = 1'b0;
    #1;
    chk("mrst_htrans", {30'h0, HTRANS}, 32'h0);
    chk("mrst_haddr", HADDR, 32'h0);
    chk("mrst_hwrite", {31'h0, HWRITE}, 32'h0);
    chk("mrst_hsize", {29'h0, HSIZE}, 32'h0);
    chk("mrst_hwdata", HWDATA, 32'h0);
    chk("mrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    idle_cmd;
    tick;
    tick;
    HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("mrst_no_rsp", {31'h0, rsp_valid}, 32'h0);
      chk("mrst_idle", {31'h0, busy}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb_cmd_master.md
Name: ahb_cmd_master

Overview:
- AHB-Lite single-master initiator that converts a simple valid/ready command stream into single-beat AHB-Lite transfers.
- Drives the same AHB-Lite fabric as the on-chip SRAM and peripheral slaves. Used for the boot loader and debug access paths.
- Address phase of command N+1 overlaps the data phase of command N. Throughput is 1 transfer/cycle with zero-wait slaves.
- Handles wait states and the two-cycle ERROR response. Performs byte-lane steering for byte and halfword accesses.

Parameters:
- HPROT_VAL, 4'b0011, constant value driven on HPROT (non-cacheable, non-bufferable, privileged, data).
- ERR_CANCEL, 1, 1: cancel the pending address-phase command after an ERROR response; 0: let it issue.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  2  0 byte, 1 halfword, 2 word; 3 treated as word
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data, right-aligned
- rsp_valid  out  1  one-cycle pulse per command, in command order
- rsp_rdata  out  32  read data, right-aligned, zero-extended; 0 for writes
- rsp_err  out  1  qualifies rsp_valid: bus ERROR or cancelled command
- busy  out  1  address phase or data phase outstanding
- HADDR  out  32  AHB address
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only
- HWRITE  out  1  AHB write
- HSIZE  out  3  {1'b0, size}
- HBURST  out  3  constant 3'b000 (SINGLE)
- HPROT  out  4  HPROT_VAL
- HMASTLOCK  out  1  constant 0
- HWDATA  out  32  lane-steered write data
- HRDATA  in  32  read data from slave mux
- HREADY  in  1  system HREADY
- HRESP  in  1  0 OKAY, 1 ERROR

Behaviour:
- Reset (async): HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. All address- and data-phase valid flags are cleared. Reset mid-transfer drops everything and issues no response.
- Address-phase register (AP): holds addr, write, size, wdata, valid. All AHB address/control outputs come straight from AP flops (no combinational paths from cmd_* to the bus).
- cmd_ready = (~AP.valid || HREADY) && ~err_first. Here err_first = DP.valid && HRESP && ~HREADY.
- On a cmd handshake:
  - AP loads the command, with low address bits cleared to natural alignment (halfword: addr[0]=0; word: addr[1:0]=0).
  - HTRANS=NONSEQ from the next cycle.
- If AP.valid && HREADY and there is no new command, HTRANS returns to IDLE next cycle.
- AP->DP handoff: when HREADY=1 and AP.valid, the data-phase register (DP) captures write, size, addr[1:0] and wdata.
- HWDATA is driven from DP with lane steering:
  - byte: replicated on all 4 lanes;
  - halfword: [15:0] replicated on both halves;
  - word: passed through unchanged.
- Completion: when DP.valid && HREADY, the data phase ends.
  - rsp_valid=1 for one cycle, on the clock edge after completion (registered).
  - rsp_err=HRESP.
  - rsp_rdata = lane selected by DP.addr[1:0]/size, zero-extended. Writes give rsp_rdata=0.
- Wait states: while HREADY=0, AP and HTRANS hold stable and HWDATA holds stable. No response is produced.
- ERROR, first cycle (HRESP=1, HREADY=0):
  - cmd_ready=0.
  - If ERR_CANCEL=1 and AP.valid: AP is cleared at that edge, so HTRANS=IDLE in the second cycle.
  - The cancelled command is reported as rsp_valid/rsp_err=1 one cycle after the erroring transfer's response.
- ERROR, second cycle (HRESP=1, HREADY=1): completes the transfer as an error per the completion rule.
- Simultaneous completion and accept: allowed; this is the back-to-back pipelined case.
- Response latency: address phase at cycle T with zero wait states → rsp_valid at T+2.
- busy = AP.valid || DP.valid || pending cancel report.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ;
  - HSIZE encodings;
  - HBURST_SINGLE;
  - HRESP_OKAY/HRESP_ERROR.
- One natural sub-module: ahb_lane_steer. It is pure combinational write replication and read extraction by size/addr[1:0], and is reusable by future masters.

Test Plan:
- Word write 0xDEADBEEF to 0x0000_0010, then word read of the same address, zero-wait SRAM slave → HTRANS NONSEQ on two consecutive cycles; rsp_rdata=0xDEADBEEF two cycles after the read address phase.
- Byte write 0xA5 to 0x13 → HWDATA=0xA5A5A5A5 with HSIZE=0. A later word read of 0x10 → byte 3 = 0xA5; byte read of 0x13 → rsp_rdata=0x000000A5.
- Halfword read at odd address 0x23 → HADDR=0x22, HSIZE=1; rsp_rdata = upper halfword of word 0x20.
- Slave inserts 3 wait states on a read → HADDR/HTRANS/HWDATA stable, cmd_ready=0 for 3 cycles; exactly one rsp_valid afterwards.
- Two-cycle ERROR on transfer A with command B in address phase, ERR_CANCEL=1 → HTRANS=IDLE in the second error cycle; rsp A err=1, then rsp B err=1; B never appears on the bus.
- Eight back-to-back word writes, zero wait → eight consecutive NONSEQ cycles and eight consecutive rsp_valid pulses. Asserting HRESETn low mid-stream → all outputs at reset values immediately; no further rsp_valid.
